// File: rtl/filter_wb_pkg.sv
// Shared types and constants for the filter write-back stage.
package filter_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2
  } wb_state_t;

  localparam int PIXEL_W   = 32;
  localparam int ADDR_STEP = 4;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous pixel FIFO with a combinational head output.
// Depth must be a power of two so the pointers wrap naturally.
module wb_fifo
  import filter_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = PIXEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // Requests that would overflow or underflow are dropped here as a safety net.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  assign rdata = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/filter_writeback.sv
// Filter write-back stage: buffers incoming pixels and writes them to
// consecutive word addresses of frame memory, one job per start pulse.
// Optional stall counter output enabled by defining FILTER_WB_STALL_CNT_EN.
module filter_writeback
  import filter_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int COUNT_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] pixel_count,
  input  logic               pix_valid,
  input  logic [31:0]        pix_data,
  output logic               pix_ready,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               done
`ifdef FILTER_WB_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  wb_state_t          r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [COUNT_W-1:0] r_len;
  logic [COUNT_W-1:0] r_accepted;
  logic [COUNT_W-1:0] r_written;

  logic               w_active;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [PIXEL_W-1:0] w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_start_ok;

  assign w_active   = (r_state == ACTIVE);
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_push     = pix_valid && pix_ready;
  assign w_pop      = mem_write && mem_ack;

  // Never accept more pixels than the job asked for.
  assign pix_ready = w_active && !w_fifo_full && (r_accepted < r_len);
  assign mem_write = w_active && !w_fifo_empty;
  assign mem_addr  = r_addr;
  // Head is held by the FIFO until the ack pops it; force zero when idle so
  // stale or uninitialised storage never shows on the bus.
  assign mem_wdata = mem_write ? w_head : '0;
  assign busy      = w_active;
  assign done      = (r_state == FINISH);

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (PIXEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (pix_data),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Job control FSM: latch job on start, count accepted/written pixels, step address per ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_written  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr     <= {base_addr[ADDR_W-1:2], 2'b00};
            r_len      <= pixel_count;
            r_accepted <= '0;
            r_written  <= '0;
            r_state    <= (pixel_count != '0) ? ACTIVE : FINISH;
          end
        end
        ACTIVE: begin
          if (w_push) begin
            r_accepted <= r_accepted + COUNT_W'(1);
          end
          if (w_pop) begin
            r_addr    <= r_addr + ADDR_W'(ADDR_STEP);
            r_written <= r_written + COUNT_W'(1);
            if (r_written == r_len - COUNT_W'(1)) begin
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FILTER_WB_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles a write request waited for its ack in the current job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_start_ok) begin
      r_stall_cycles <= '0;
    end else if (mem_write && !mem_ack && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_filter_writeback.sv
// Directed testbench for filter_writeback: a table of jobs driven through a
// common job runner, plus hand-written reset-abort sequence.
module tb_filter_writeback;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 32;
  localparam int COUNT_W    = 20;
  localparam int NJOBS      = 6;

  logic               clk;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [COUNT_W-1:0] pixel_count;
  logic               pix_valid;
  logic [31:0]        pix_data;
  logic               pix_ready;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_ack;
  logic               busy;
  logic               done;
`ifdef FILTER_WB_STALL_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]      base;
    logic [19:0]      count;
    int               offered;      // pixels the upstream tries to send
    int               ack_low;      // write-request cycles held without ack
    int               mid_start;    // cycle of a spurious start (-1: none)
    int               exp_accepted; // pixels expected accepted and written
    int               exp_done;     // cycle index of done (-1: not checked)
    logic [7:0][31:0] pix;
  } job_t;

  job_t jobs [NJOBS];

  filter_writeback #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .pixel_count  (pixel_count),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .done         (done)
`ifdef FILTER_WB_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input logic [31:0] base, input logic [19:0] count,
                              input int offered, input int ack_low, input int mid_start,
                              input int exp_acc, input int exp_done, input logic [31:0] seed);
    job_t j;
    j.base         = base;
    j.count        = count;
    j.offered      = offered;
    j.ack_low      = ack_low;
    j.mid_start    = mid_start;
    j.exp_accepted = exp_acc;
    j.exp_done     = exp_done;
    for (int k = 0; k < 8; k++) begin
      j.pix[k] = seed + 32'(k) * 32'h0103_0507;
    end
    return j;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_addr"},  mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
`ifdef FILTER_WB_STALL_CNT_EN
    check({tag, "_stall"},     stall_cycles,   32'd0);
`endif
  endtask

  // Entered and left at posedge+1. Cycle index c=0 is the cycle after the start edge.
  task automatic run_job(input job_t j, input int id);
    int          offer_idx = 0;
    int          wr_idx    = 0;
    int          stalls    = 0;
    bit          done_seen = 0;
    logic [31:0] base_al;
    logic [31:0] exp_addr;
    base_al     = {j.base[31:2], 2'b00};
    start       = 1'b1;
    base_addr   = j.base;
    pixel_count = j.count;
    pix_valid   = 1'b0;
    mem_ack     = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      pix_valid = (offer_idx < j.offered);
      pix_data  = 32'h0;
      if (offer_idx < 8) pix_data = j.pix[offer_idx];
      mem_ack   = (j.ack_low == 0) ? 1'b1 : !(mem_write && (stalls < j.ack_low));
      start     = (c == j.mid_start);
      if (start) begin
        base_addr   = 32'h0000_9000;
        pixel_count = 20'd1;
      end
      @(negedge clk);
      if (c == 0) begin
        check("busy_after_start",  32'(busy),      32'(j.count != 0));
        check("ready_after_start", 32'(pix_ready), 32'(j.count != 0));
      end
      if (j.count == 0) check("zero_count_no_write", 32'(mem_write), 32'd0);
      if (done) begin
        check("busy_in_finish", 32'(busy), 32'd0);
        if (j.exp_done >= 0) check("done_cycle", 32'(c), 32'(j.exp_done));
        done_seen = 1'b1;
        break;
      end
      if (mem_write) begin
        exp_addr = base_al + 32'(4 * wr_idx);
        check("mem_addr", mem_addr, exp_addr);
        if (wr_idx < 8) check("mem_wdata", mem_wdata, j.pix[wr_idx]);
        if (mem_ack) begin
          $display("job %0d write %0d addr=0x%08h data=0x%08h", id, wr_idx, mem_addr, mem_wdata);
        end else begin
          stalls++;
          if (stalls == j.ack_low) begin
            check("bp_accepted", 32'(offer_idx), 32'(FIFO_DEPTH));
            check("bp_ready_low", 32'(pix_ready), 32'd0);
          end
        end
      end
      if (mem_write && mem_ack) wr_idx++;
      if (pix_valid && pix_ready) offer_idx++;
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout job=%0d actual=no_done required=done", id);
    end
    check("accepted", 32'(offer_idx), 32'(j.exp_accepted));
    check("written",  32'(wr_idx),    32'(j.exp_accepted));
`ifdef FILTER_WB_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 32'(j.ack_low));
`endif
    $display("job %0d base=0x%08h count=%0d accepted=%0d written=%0d", id, j.base, j.count, offer_idx, wr_idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    pixel_count = '0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    mem_ack     = 1'b0;

    //          base          cnt  off ackl mid acc done seed
    jobs[0] = mk(32'h0000_1000, 3, 3, 0,  -1, 3, 4,  32'h0);
    jobs[0].pix[0] = 32'hFF21_3512;
    jobs[0].pix[1] = 32'hFF34_F4FF;
    jobs[0].pix[2] = 32'hFF09_0909;
    jobs[1] = mk(32'h0000_2000, 0, 0, 0,  -1, 0, 0,  32'h1111_0000);
    jobs[2] = mk(32'h0000_3000, 2, 5, 0,  -1, 2, 3,  32'h2222_0000);
    jobs[3] = mk(32'hFFFF_FFFE, 2, 2, 0,  -1, 2, 3,  32'h3333_0000);
    jobs[4] = mk(32'h0000_4000, 6, 6, 10, -1, 6, -1, 32'h4444_0000);
    jobs[5] = mk(32'h0000_6000, 3, 3, 0,  1,  3, 4,  32'h5555_0000);

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NJOBS; i++) begin
      run_job(jobs[i], i);
    end

    // Abort mid-job with two pixels buffered and the write stalled.
    start       = 1'b1;
    base_addr   = 32'h0000_5000;
    pixel_count = 20'd4;
    mem_ack     = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pix_valid = 1'b1;
      pix_data  = 32'hA5A5_0000 + 32'(k);
      @(negedge clk);
      check("abort_ready", 32'(pix_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_write", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_abort_done",  32'(done),      32'd0);
      check("post_abort_write", 32'(mem_write), 32'd0);
      check("post_abort_busy",  32'(busy),      32'd0);
    end
    @(posedge clk);
    #1;
    $display("abort sequence complete");

    // A fresh job after the abort must see an empty FIFO.
    run_job(jobs[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
